// File: rtl/kd_tree_seq_ctrl.sv
// kd_tree_seq_ctrl: sequencer for the command/data top port of a kd-tree root node.
// Each run has three phases: reset the tree, fill NUM_CENTERS centers from a
// valid/ready stream, then issue start_sorting and wait for valid_sort.
// Every phase that waits on the root has a timeout, which ends the run in ERR.
// Optional build macro KD_TREE_SEQ_PERF_EN adds the run_cycles/stall_cycles counters.
module kd_tree_seq_ctrl #(
   parameter int CMD_W       = 5,
   parameter int DATA_W      = 24,
   parameter int NUM_CENTERS = 7,
   parameter int TIMEOUT     = 1024,
   parameter int CNT_W       = $clog2(NUM_CENTERS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] center_data,
   input  logic              center_valid,
   output logic              center_ready,
   input  logic [CMD_W-1:0]  root_cmd_in,
   output logic [CMD_W-1:0]  root_cmd_out,
   output logic [DATA_W-1:0] root_data_out,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_phase
`ifdef KD_TREE_SEQ_PERF_EN
   ,
   output logic [31:0]       run_cycles,
   output logic [31:0]       stall_cycles
`endif
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_CENTERS);

   localparam logic [CMD_W-1:0] CMD_NOP           = CMD_W'('h00);
   localparam logic [CMD_W-1:0] CMD_RST           = CMD_W'('h1f);
   localparam logic [CMD_W-1:0] CMD_RST_DONE      = CMD_W'('h1e);
   localparam logic [CMD_W-1:0] CMD_FILL          = CMD_W'('h01);
   localparam logic [CMD_W-1:0] CMD_FILL_DONE     = CMD_W'('h05);
   localparam logic [CMD_W-1:0] CMD_START_SORTING = CMD_W'('h09);
   localparam logic [CMD_W-1:0] CMD_VALID_SORT    = CMD_W'('h0f);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_FILL,
      S_SORT_ISSUE,
      S_SORT_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] sent_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_exp;
   logic             fill_full;
   logic             fill_xfer;
   logic             launch;
   logic [1:0]       err_code;

   assign center_ready = (state == S_FILL) && (sent_cnt < CNT_FULL);
   assign fill_full    = (sent_cnt == CNT_FULL);
   assign fill_xfer    = center_valid && center_ready;
   assign tmo_exp      = (tmo_cnt == TMO_LAST);

   // Next-state decode; abort overrides every other transition, including start.
   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      err_code  = 2'd0;
      unique case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_nxt = S_RST;
               launch    = 1'b1;
            end
         end
         S_RST: begin
            err_code = 2'd1;
            if (root_cmd_in == CMD_RST_DONE) state_nxt = S_FILL;
            else if (tmo_exp)                state_nxt = S_ERR;
         end
         S_FILL: begin
            err_code = 2'd2;
            // fill_done wins over a timeout; a word handshaken this cycle is still sent
            if (root_cmd_in == CMD_FILL_DONE) state_nxt = S_SORT_ISSUE;
            else if (fill_full && tmo_exp)    state_nxt = S_ERR;
         end
         S_SORT_ISSUE: begin
            if (root_cmd_in == CMD_VALID_SORT) state_nxt = S_DONE;
            else                               state_nxt = S_SORT_WAIT;
         end
         S_SORT_WAIT: begin
            err_code = 2'd3;
            if (root_cmd_in == CMD_VALID_SORT) state_nxt = S_DONE;
            else if (tmo_exp)                  state_nxt = S_ERR;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (abort) begin
         state_nxt = S_IDLE;
         launch    = 1'b0;
      end
   end

   // Sequencer state, counters and registered root/status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         sent_cnt      <= '0;
         tmo_cnt       <= '0;
         root_cmd_out  <= CMD_NOP;
         root_data_out <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         err_phase     <= 2'd0;
      end else begin
         state <= state_nxt;

         // FILL only arms its timeout once every center has been sent
         if (state_nxt != state || (state == S_FILL && !fill_full)) tmo_cnt <= '0;
         else                                                        tmo_cnt <= tmo_cnt + 1'b1;

         if (abort || launch)                   sent_cnt <= '0;
         else if (state == S_FILL && fill_xfer) sent_cnt <= sent_cnt + 1'b1;

         root_cmd_out <= CMD_NOP;
         if (!abort) begin
            unique case (state)
               S_RST: root_cmd_out <= CMD_RST;
               S_FILL: begin
                  if (fill_xfer) begin
                     root_cmd_out  <= CMD_FILL;
                     root_data_out <= center_data;
                  end
               end
               S_SORT_ISSUE: begin
                  root_cmd_out  <= CMD_START_SORTING;
                  root_data_out <= '0;
               end
               default: root_cmd_out <= CMD_NOP;
            endcase
         end

         busy  <= state_nxt inside {S_RST, S_FILL, S_SORT_ISSUE, S_SORT_WAIT};
         done  <= (state_nxt == S_DONE);
         error <= (state_nxt == S_ERR);

         if (state_nxt == S_ERR && state != S_ERR) err_phase <= err_code;
         else if (state_nxt != S_ERR)              err_phase <= 2'd0;
      end
   end

`ifdef KD_TREE_SEQ_PERF_EN
   // Saturating run-length and input-stall counters, cleared when a run launches.
   always_ff @(posedge clk) begin
      if (reset) begin
         run_cycles   <= '0;
         stall_cycles <= '0;
      end else if (launch) begin
         run_cycles   <= '0;
         stall_cycles <= '0;
      end else begin
         if ((state inside {S_RST, S_FILL, S_SORT_ISSUE, S_SORT_WAIT}) && run_cycles != '1)
            run_cycles <= run_cycles + 1'b1;
         if (center_ready && !center_valid && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_kd_tree_seq_ctrl.sv
// Table-driven bench for kd_tree_seq_ctrl. Each row holds the inputs for one
// cycle and the outputs expected in that same cycle (sampled at the negedge).
// u_dut uses TIMEOUT=16; u_d8 (TIMEOUT=8) shares all inputs and is checked only
// in the input-starvation segment.
module tb_kd_tree_seq_ctrl;

   localparam logic [4:0] C_NOP  = 5'h00;
   localparam logic [4:0] C_RST  = 5'h1f;
   localparam logic [4:0] C_RD   = 5'h1e;
   localparam logic [4:0] C_FILL = 5'h01;
   localparam logic [4:0] C_FD   = 5'h05;
   localparam logic [4:0] C_SS   = 5'h09;
   localparam logic [4:0] C_VS   = 5'h0f;

   localparam int M_NORM     = 0;
   localparam int M_EARLY    = 1;
   localparam int M_SORT_TMO = 2;
   localparam int M_FILL_TMO = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [23:0] center_data = '0;
   logic        center_valid = 1'b0;
   logic [4:0]  root_cmd_in = '0;

   logic        ready_a, busy_a, done_a, error_a;
   logic [4:0]  cmd_a;
   logic [23:0] data_a;
   logic [1:0]  ep_a;
   logic        ready_b, busy_b, done_b, error_b;
   logic [4:0]  cmd_b;
   logic [23:0] data_b;
   logic [1:0]  ep_b;
`ifdef KD_TREE_SEQ_PERF_EN
   logic [31:0] run_a, stall_a, run_b, stall_b;
`endif

   always #5 clk = ~clk;

   kd_tree_seq_ctrl #(.CMD_W(5), .DATA_W(24), .NUM_CENTERS(7), .TIMEOUT(16)) u_dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .center_data(center_data), .center_valid(center_valid), .center_ready(ready_a),
      .root_cmd_in(root_cmd_in), .root_cmd_out(cmd_a), .root_data_out(data_a),
      .busy(busy_a), .done(done_a), .error(error_a), .err_phase(ep_a)
`ifdef KD_TREE_SEQ_PERF_EN
      , .run_cycles(run_a), .stall_cycles(stall_a)
`endif
   );

   kd_tree_seq_ctrl #(.CMD_W(5), .DATA_W(24), .NUM_CENTERS(7), .TIMEOUT(8)) u_d8 (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .center_data(center_data), .center_valid(center_valid), .center_ready(ready_b),
      .root_cmd_in(root_cmd_in), .root_cmd_out(cmd_b), .root_data_out(data_b),
      .busy(busy_b), .done(done_b), .error(error_b), .err_phase(ep_b)
`ifdef KD_TREE_SEQ_PERF_EN
      , .run_cycles(run_b), .stall_cycles(stall_b)
`endif
   );

   typedef struct {
      logic        rst;
      logic        start;
      logic        abort;
      logic        valid;
      logic [23:0] cdata;
      logic [4:0]  rin;
      logic [4:0]  cmd;
      logic [23:0] data;
      logic [5:0]  flags;   // {ready, busy, done, error, err_phase}
      logic        chk8;
   } vec_t;

   vec_t vecs[$];
   bit   g_chk8 = 1'b0;
   int   checks = 0;
   int   failures = 0;

   task automatic add(input logic st, input logic ab, input logic va, input logic [23:0] cd,
                      input logic [4:0] ri, input logic [4:0] cmd, input logic [23:0] dat,
                      input logic rdy, input logic bsy, input logic dn, input logic er,
                      input logic [1:0] ep);
      vec_t v;
      v.rst   = 1'b0;
      v.start = st;
      v.abort = ab;
      v.valid = va;
      v.cdata = cd;
      v.rin   = ri;
      v.cmd   = cmd;
      v.data  = dat;
      v.flags = {rdy, bsy, dn, er, ep};
      v.chk8  = g_chk8;
      vecs.push_back(v);
   endtask

   task automatic add_reset();
      vec_t v;
      v.rst   = 1'b1;
      v.start = 1'b0;
      v.abort = 1'b0;
      v.valid = 1'b0;
      v.cdata = '0;
      v.rin   = C_NOP;
      v.cmd   = C_NOP;
      v.data  = '0;
      v.flags = '0;
      v.chk8  = 1'b0;
      vecs.push_back(v);
   endtask

   // One run launched from IDLE/DONE/ERR. pd/pe/pep/pdata describe the state seen
   // in the launch cycle. Root answers rst_done 3 cycles after the first rst beat,
   // centers 1..7 are always valid, fill_done comes 2 cycles after the 7th beat.
   task automatic nom_run(input logic pd, input logic pe, input logic [1:0] pep,
                          input logic [23:0] pdata, input int mode, input int abort_after);
      add(1, 0, 0, 0, C_NOP, C_NOP, pdata, 0, 0, pd, pe, pep);
      add(0, 0, 0, 0, C_NOP, C_NOP, pdata, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 0, C_NOP, C_RST, pdata, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, C_RD, C_RST, pdata, 0, 1, 0, 0, 0);
      for (int k = 1; k <= 7; k++) begin
         if (abort_after > 0 && k == abort_after + 1) begin
            add(0, 1, 0, 0, C_NOP, C_FILL, 24'(k - 1), 1, 1, 0, 0, 0);
            add(0, 0, 0, 0, C_NOP, C_NOP, 24'(k - 1), 0, 0, 0, 0, 0);
            return;
         end
         add(0, 0, 1, 24'(k), C_NOP, (k == 1) ? C_RST : C_FILL, (k == 1) ? pdata : 24'(k - 1),
             1, 1, 0, 0, 0);
      end
      if (mode == M_FILL_TMO) begin
         add(0, 0, 0, 0, C_NOP, C_FILL, 24'd7, 0, 1, 0, 0, 0);
         for (int i = 0; i < 15; i++) add(0, 0, 0, 0, C_NOP, C_NOP, 24'd7, 0, 1, 0, 0, 0);
         add(0, 0, 0, 0, C_NOP, C_NOP, 24'd7, 0, 0, 0, 1, 2'd2);
         return;
      end
      add(0, 0, 1, 24'd8, C_NOP, C_FILL, 24'd7, 0, 1, 0, 0, 0);
      add(0, 0, 1, 24'd8, C_NOP, C_NOP, 24'd7, 0, 1, 0, 0, 0);
      add(0, 0, 1, 24'd8, C_FD, C_NOP, 24'd7, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, (mode == M_EARLY) ? C_VS : C_NOP, C_NOP, 24'd7, 0, 1, 0, 0, 0);
      if (mode == M_EARLY) begin
         add(0, 0, 0, 0, C_NOP, C_SS, 24'd0, 0, 0, 1, 0, 0);
         return;
      end
      add(0, 0, 0, 0, C_NOP, C_SS, 24'd0, 0, 1, 0, 0, 0);
      if (mode == M_SORT_TMO) begin
         for (int i = 0; i < 15; i++) add(0, 0, 0, 0, C_NOP, C_NOP, 24'd0, 0, 1, 0, 0, 0);
         add(0, 0, 0, 0, C_NOP, C_NOP, 24'd0, 0, 0, 0, 1, 2'd3);
         return;
      end
      for (int i = 0; i < 9; i++) add(0, 0, 0, 0, C_NOP, C_NOP, 24'd0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, C_VS, C_NOP, 24'd0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, C_NOP, C_NOP, 24'd0, 0, 0, 1, 0, 0);
   endtask

   task automatic compare(input string who, input int row, input logic [4:0] cmd,
                          input logic [23:0] dat, input logic [5:0] flags, input vec_t v);
      checks++;
      if ({cmd, dat, flags} !== {v.cmd, v.data, v.flags}) begin
         failures++;
         $display("FAIL %s row %0d: got cmd=%h data=%h flags=%b, want cmd=%h data=%h flags=%b",
                  who, row, cmd, dat, flags, v.cmd, v.data, v.flags);
      end
   endtask

   initial begin
      // nominal run
      add_reset();
      nom_run(0, 0, 2'd0, 24'd0, M_NORM, 0);

      // reset-phase timeout: 16 rst beats, then ERR with phase 1
      add_reset();
      add(1, 0, 0, 0, C_NOP, C_NOP, 24'd0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, C_NOP, C_NOP, 24'd0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 15; i++) add(0, 0, 0, 0, C_NOP, C_RST, 24'd0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, C_NOP, C_RST, 24'd0, 0, 0, 0, 1, 2'd1);
      add(0, 0, 0, 0, C_NOP, C_NOP, 24'd0, 0, 0, 0, 1, 2'd1);

      // re-run from ERR, sort timeout, re-run with early valid_sort
      nom_run(0, 1, 2'd1, 24'd0, M_SORT_TMO, 0);
      nom_run(0, 1, 2'd3, 24'd0, M_EARLY, 0);

      // abort after three centers, then full fill that times out, then nominal
      nom_run(1, 0, 2'd0, 24'd0, M_NORM, 3);
      nom_run(0, 0, 2'd0, 24'd3, M_FILL_TMO, 0);
      nom_run(0, 1, 2'd2, 24'd7, M_NORM, 0);

      // start and abort together in DONE: abort wins
      add(1, 1, 0, 0, C_NOP, C_NOP, 24'd0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, C_NOP, C_NOP, 24'd0, 0, 0, 0, 0, 0);

      // reset in the middle of the rst phase
      add(1, 0, 0, 0, C_NOP, C_NOP, 24'd0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, C_NOP, C_NOP, 24'd0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, C_NOP, C_RST, 24'd0, 0, 1, 0, 0, 0);
      add_reset();
      add(0, 0, 0, 0, C_NOP, C_NOP, 24'd0, 0, 0, 0, 0, 0);

      // input starvation, checked on both instances
      add_reset();
      g_chk8 = 1'b1;
      add(1, 0, 0, 0, C_NOP, C_NOP, 24'd0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, C_NOP, C_NOP, 24'd0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 0, C_NOP, C_RST, 24'd0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, C_RD, C_RST, 24'd0, 0, 1, 0, 0, 0);
      add(0, 0, 1, 24'd1, C_NOP, C_RST, 24'd0, 1, 1, 0, 0, 0);
      for (int j = 7; j <= 18; j++) begin
         if (j % 2 == 1) add(0, 0, 0, 0, C_NOP, C_FILL, 24'((j - 5) / 2), 1, 1, 0, 0, 0);
         else add(0, 0, 1, 24'((j - 6) / 2 + 1), C_NOP, C_NOP, 24'((j - 6) / 2), 1, 1, 0, 0, 0);
      end
      add(0, 0, 0, 0, C_NOP, C_FILL, 24'd7, 0, 1, 0, 0, 0);
      add(0, 0, 1, 24'd8, C_NOP, C_NOP, 24'd7, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, C_FD, C_NOP, 24'd7, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, C_NOP, C_NOP, 24'd7, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, C_NOP, C_SS, 24'd0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, C_NOP, C_NOP, 24'd0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, C_VS, C_NOP, 24'd0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, C_NOP, C_NOP, 24'd0, 0, 0, 1, 0, 0);

      repeat (2) @(posedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset        = vecs[i].rst;
         start        = vecs[i].start;
         abort        = vecs[i].abort;
         center_valid = vecs[i].valid;
         center_data  = vecs[i].cdata;
         root_cmd_in  = vecs[i].rin;
         if (!vecs[i].rst) begin
            compare("dut", i, cmd_a, data_a, {ready_a, busy_a, done_a, error_a, ep_a}, vecs[i]);
            if (vecs[i].chk8)
               compare("d8", i, cmd_b, data_b, {ready_b, busy_b, done_b, error_b, ep_b}, vecs[i]);
         end
      end

`ifdef KD_TREE_SEQ_PERF_EN
      @(negedge clk);
      checks += 4;
      if (run_a !== 32'd25) begin
         failures++;
         $display("FAIL run_cycles dut: got %0d want 25", run_a);
      end
      if (stall_a !== 32'd6) begin
         failures++;
         $display("FAIL stall_cycles dut: got %0d want 6", stall_a);
      end
      if (run_b !== 32'd25) begin
         failures++;
         $display("FAIL run_cycles d8: got %0d want 25", run_b);
      end
      if (stall_b !== 32'd6) begin
         failures++;
         $display("FAIL stall_cycles d8: got %0d want 6", stall_b);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
